ycbcr2rgb_stream: RTL and testbench
===================================

YCBCR2RGB_STREAM -- requirements
Module: ycbcr2rgb_stream

Interface
REQ-001 SHALL have parameter PARALLEL_NUM, default 4: pixels per beat (4 = 96-bit RGB beat).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries (power of 2, at least 8).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports i_y, i_cb, i_cr, input, each PARALLEL_NUM x 8 bits: studio-range YCbCr pixels, lane 0 = first pixel.
REQ-006 SHALL have ports i_valid, i_last, i_user, input, 1 bit each: upstream beat qualifiers.
REQ-007 SHALL have port o_ready, output, 1 bit: upstream may transfer a beat.
REQ-008 SHALL have ports o_r, o_g, o_b, output, each PARALLEL_NUM x 8 bits: RGB result.
REQ-009 SHALL have ports o_valid, o_last, o_user, output, 1 bit each: downstream beat qualifiers.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts a beat.

Function
REQ-011 SHALL transfer an upstream beat on i_valid && o_ready, and a downstream beat on o_valid && i_ready.
REQ-012 SHALL compute per lane, in signed 20-bit arithmetic with yd = Y-16, cbd = Cb-128, crd = Cr-128:
- R = (298*yd + 409*crd + 128) >>> 8
- G = (298*yd - 100*cbd - 208*crd + 128) >>> 8
- B = (298*yd + 516*cbd + 128) >>> 8
REQ-013 SHALL clamp each result to 0..255: negative gives 0, above 255 gives 255.
REQ-014 SHALL use a 4-stage, never-stalling compute pipeline:
- stage 1: offset subtract
- stage 2: multiply
- stage 3: sum and round
- stage 4: clamp
REQ-015 SHALL delay last and user alongside data through the pipeline, keeping bit-exact alignment with the data beat.
REQ-016 SHALL write stage-4 output into a FIFO_DEPTH-entry FIFO; the FIFO head drives o_r, o_g, o_b, o_last, o_user, and o_valid = FIFO not empty.
REQ-017 SHALL track a credit count = FIFO occupancy + valid beats in stages 1-4, and drive o_ready = (credit < FIFO_DEPTH) from registers only, with no combinational path from i_ready.
REQ-018 SHALL never overflow the FIFO and never drop or duplicate a beat under any i_ready pattern.
REQ-019 SHALL reach o_valid 5 cycles after acceptance when the FIFO is empty: 4 pipeline cycles + 1 write cycle.
REQ-020 SHALL, on a simultaneous FIFO write and read, leave occupancy unchanged; a simultaneous accept and downstream pop SHALL leave credit unchanged.
REQ-021 SHALL hold o_r, o_g, o_b, o_last, o_user stable while o_valid && !i_ready.
REQ-022 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH, and distinguish full from empty by a separate count.

Reset
REQ-023 SHALL clear on i_rst at a clock edge: pipeline valids, FIFO pointers and count, and the credit count; o_valid = 0 and o_ready = 1 in the cycle after reset.
REQ-024 SHALL reset o_r, o_g, o_b, o_last, o_user to 0; pipeline data registers need no reset.
REQ-025 SHALL, on reset mid-stream, discard all in-flight and buffered beats without emitting partial output.

Structure
REQ-026 SHALL define in shared package ycbcr2rgb_pkg:
- coefficient constants (298, 409, 208, 100, 516, offsets 16/128, rounding 128)
- the 8-bit pixel lane typedef
- the 20-bit signed intermediate typedef
REQ-027 SHALL contain one sub-module, sync_fifo: width = 3*8*PARALLEL_NUM+2, depth FIFO_DEPTH, synchronous active-high reset.

Verification
REQ-028 SHALL cover: Y=16, Cb=128, Cr=128 on all lanes, i_ready=1 -> RGB (0,0,0), o_valid 5 cycles after accept.
REQ-029 SHALL cover: Y=235, Cb=128, Cr=128 -> (255,255,255); Y=81, Cb=90, Cr=240 -> (255,0,0), with B clamped from -1.
REQ-030 SHALL cover: Y=255, Cb=255, Cr=255 -> (255,125,255), confirming R and B upper clamps and G unclamped.
REQ-031 SHALL cover: continuous i_valid with i_ready=0 for 20 cycles -> exactly 8 beats accepted, o_ready low afterward; releasing i_ready drains all 8 in order with last/user intact.
REQ-032 SHALL cover: random i_valid and i_ready over 10,000 beats, compared against a reference model -> zero mismatches and no loss.
REQ-033 SHALL cover: i_rst asserted with 3 beats in the pipeline and 5 in the FIFO -> next cycle o_valid=0, o_ready=1, and no stale beat is ever emitted.

Source files
------------

// File: rtl/ycbcr2rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr2rgb_pkg
// Description : Shared types and BT.601 studio-range conversion constants for
//               the YCbCr to RGB stream converter.
// Revision    : 1.0 - initial release
// ============================================================================
package ycbcr2rgb_pkg;

    // One 8-bit colour component of one pixel lane
    typedef logic [7:0] pixel_t;

    // Signed intermediate wide enough for every product and sum in the datapath
    typedef logic signed [19:0] calc_t;

    localparam calc_t c_coef_y    = 20'sd298;
    localparam calc_t c_coef_r_cr = 20'sd409;
    localparam calc_t c_coef_g_cr = 20'sd208;
    localparam calc_t c_coef_g_cb = 20'sd100;
    localparam calc_t c_coef_b_cb = 20'sd516;
    localparam calc_t c_offset_y  = 20'sd16;
    localparam calc_t c_offset_c  = 20'sd128;
    localparam calc_t c_round     = 20'sd128;

    // Saturate a signed intermediate into the 0..255 pixel range
    function automatic pixel_t clamp8(input calc_t v);
        pixel_t res;
        if (v < 20'sd0) begin
            res = 8'd0;
        end else if (v > 20'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr2rgb_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a separate occupancy count so full and
//               empty are unambiguous. Head word is presented combinationally
//               and reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_do_wr;
    logic w_do_rd;

    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_wr   = i_wr_en && !w_full;
    assign w_do_rd   = i_rd_en && !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ycbcr2rgb_stream.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr2rgb_stream
// Description : Streaming studio-range YCbCr to RGB converter. Four-stage
//               free-running datapath feeding an output FIFO; upstream ready
//               is credit based so the pipeline never has to stall.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr2rgb_stream
    import ycbcr2rgb_pkg::*;
#(
    parameter int PARALLEL_NUM = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PARALLEL_NUM*8-1:0] i_y,
    input  logic [PARALLEL_NUM*8-1:0] i_cb,
    input  logic [PARALLEL_NUM*8-1:0] i_cr,
    input  logic                      i_valid,
    input  logic                      i_last,
    input  logic                      i_user,
    output logic                      o_ready,
    output logic [PARALLEL_NUM*8-1:0] o_r,
    output logic [PARALLEL_NUM*8-1:0] o_g,
    output logic [PARALLEL_NUM*8-1:0] o_b,
    output logic                      o_valid,
    output logic                      o_last,
    output logic                      o_user,
    input  logic                      i_ready
);

    localparam int c_beat_w = PARALLEL_NUM * 8;
    localparam int c_fifo_w = 3 * c_beat_w + 2;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;

    logic w_accept;
    logic w_pop;
    logic w_empty;

    logic [c_beat_w-1:0] w_s4_r;
    logic [c_beat_w-1:0] w_s4_g;
    logic [c_beat_w-1:0] w_s4_b;
    logic [c_fifo_w-1:0] w_rd_data;

    logic [3:0] r_valid_pipe;
    logic [3:0] r_last_pipe;
    logic [3:0] r_user_pipe;

    logic [c_cnt_w-1:0] r_credit;
    logic [c_cnt_w-1:0] w_credit_next;
    logic               r_ready;

    assign w_accept = i_valid && r_ready;
    assign w_pop    = o_valid && i_ready;

    // Beat qualifiers ride a shift register matched to the datapath depth
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid_pipe <= '0;
            r_last_pipe  <= '0;
            r_user_pipe  <= '0;
        end else begin
            r_valid_pipe <= {r_valid_pipe[2:0], w_accept};
            r_last_pipe  <= {r_last_pipe[2:0], i_last};
            r_user_pipe  <= {r_user_pipe[2:0], i_user};
        end
    end

    for (genvar l = 0; l < PARALLEL_NUM; l++) begin : g_lane
        calc_t  r_s1_yd, r_s1_cbd, r_s1_crd;
        calc_t  r_s2_y, r_s2_rcr, r_s2_gcb, r_s2_gcr, r_s2_bcb;
        calc_t  r_s3_r, r_s3_g, r_s3_b;
        pixel_t r_s4_r, r_s4_g, r_s4_b;

        // Per-lane datapath: offset, multiply, sum+round, clamp
        always_ff @(posedge i_clk) begin
            r_s1_yd  <= calc_t'({12'd0, i_y[l*8 +: 8]})  - c_offset_y;
            r_s1_cbd <= calc_t'({12'd0, i_cb[l*8 +: 8]}) - c_offset_c;
            r_s1_crd <= calc_t'({12'd0, i_cr[l*8 +: 8]}) - c_offset_c;

            r_s2_y   <= c_coef_y    * r_s1_yd;
            r_s2_rcr <= c_coef_r_cr * r_s1_crd;
            r_s2_gcb <= c_coef_g_cb * r_s1_cbd;
            r_s2_gcr <= c_coef_g_cr * r_s1_crd;
            r_s2_bcb <= c_coef_b_cb * r_s1_cbd;

            r_s3_r   <= (r_s2_y + r_s2_rcr + c_round) >>> 8;
            r_s3_g   <= (r_s2_y - r_s2_gcb - r_s2_gcr + c_round) >>> 8;
            r_s3_b   <= (r_s2_y + r_s2_bcb + c_round) >>> 8;

            r_s4_r   <= clamp8(r_s3_r);
            r_s4_g   <= clamp8(r_s3_g);
            r_s4_b   <= clamp8(r_s3_b);
        end

        assign w_s4_r[l*8 +: 8] = r_s4_r;
        assign w_s4_g[l*8 +: 8] = r_s4_g;
        assign w_s4_b[l*8 +: 8] = r_s4_b;
    end

    // Credit covers every beat accepted but not yet popped, so the FIFO can
    // always absorb whatever is still in flight in the datapath.
    always_comb begin
        w_credit_next = r_credit + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
    end

    // Registered credit and upstream ready (no path from i_ready to o_ready)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_credit <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_credit <= w_credit_next;
            r_ready  <= (w_credit_next < c_cnt_w'(FIFO_DEPTH));
        end
    end

    sync_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_valid_pipe[3]),
        .i_wr_data ({r_last_pipe[3], r_user_pipe[3], w_s4_r, w_s4_g, w_s4_b}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty)
    );

    assign o_ready = r_ready;
    assign o_valid = !w_empty;
    assign {o_last, o_user, o_r, o_g, o_b} = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr2rgb_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr2rgb_stream
// Description : Self-checking bench for ycbcr2rgb_stream: directed colour
//               points, latency, backpressure, random traffic, mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr2rgb_stream;

    localparam int N  = 4;
    localparam int BW = 8 * N;
    localparam int EW = 3 * BW + 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [BW-1:0] i_y, i_cb, i_cr;
    logic          i_valid, i_last, i_user;
    logic          o_ready;
    logic [BW-1:0] o_r, o_g, o_b;
    logic          o_valid, o_last, o_user;
    logic          i_ready;

    always #5 i_clk = ~i_clk;

    ycbcr2rgb_stream #(
        .PARALLEL_NUM (N),
        .FIFO_DEPTH   (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_y     (i_y),
        .i_cb    (i_cb),
        .i_cr    (i_cr),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_user  (i_user),
        .o_ready (o_ready),
        .o_r     (o_r),
        .o_g     (o_g),
        .o_b     (o_b),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_user  (o_user),
        .i_ready (i_ready)
    );

    int            checks = 0;
    int            errors = 0;
    int            acc_count = 0;
    int            pop_count = 0;
    logic [EW-1:0] q[$];
    logic          use_const = 1'b0;
    logic [EW-1:0] const_exp = '0;
    logic          hold_flag = 1'b0;
    logic [EW-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clampi(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Reference conversion straight from the colour equations, in plain integers
    function automatic logic [EW-1:0] model_beat(input logic [BW-1:0] y, input logic [BW-1:0] cb,
                                                 input logic [BW-1:0] cr, input logic lst, input logic usr);
        logic [BW-1:0] r, g, b;
        int yd, cbd, crd;
        for (int l = 0; l < N; l++) begin
            yd  = int'(y[l*8 +: 8])  - 16;
            cbd = int'(cb[l*8 +: 8]) - 128;
            crd = int'(cr[l*8 +: 8]) - 128;
            r[l*8 +: 8] = clampi((298*yd + 409*crd + 128) >>> 8);
            g[l*8 +: 8] = clampi((298*yd - 100*cbd - 208*crd + 128) >>> 8);
            b[l*8 +: 8] = clampi((298*yd + 516*cbd + 128) >>> 8);
        end
        return {lst, usr, r, g, b};
    endfunction

    // One clock: score any pop, check stall stability, then track accepts
    task automatic cycle();
        logic          acc, pop, rst_now;
        logic [EW-1:0] got, exp_b;
        got = {o_last, o_user, o_r, o_g, o_b};
        if (hold_flag) begin
            check("hold_valid", 128'(o_valid), 128'(1));
            check("hold_data", 128'(got), 128'(hold_data));
        end
        rst_now   = i_rst;
        hold_flag = o_valid && !i_ready && !i_rst;
        hold_data = got;
        acc = i_valid && o_ready && !i_rst;
        pop = o_valid && i_ready && !i_rst;
        exp_b = use_const ? const_exp : model_beat(i_y, i_cb, i_cr, i_last, i_user);
        if (pop) begin
            check("beat_expected", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0) begin
                check("beat", 128'(got), 128'(q.pop_front()));
            end
            pop_count++;
        end
        @(posedge i_clk);
        #1;
        if (rst_now) begin
            q.delete();
        end
        if (acc) begin
            q.push_back(exp_b);
            acc_count++;
        end
    endtask

    task automatic rand_inputs();
        i_y    = $urandom;
        i_cb   = $urandom;
        i_cr   = $urandom;
        i_last = 1'($urandom_range(0, 1));
        i_user = 1'($urandom_range(0, 1));
    endtask

    task automatic send_const(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                              input logic lst, input logic usr, input logic [7:0] er,
                              input logic [7:0] eg, input logic [7:0] eb);
        i_y = {N{y}}; i_cb = {N{cb}}; i_cr = {N{cr}};
        i_last = lst; i_user = usr; i_valid = 1'b1;
        use_const = 1'b1;
        const_exp = {lst, usr, {N{er}}, {N{eg}}, {N{eb}}};
        cycle();
        use_const = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while ((q.size() != 0 || o_valid) && n < bound) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int lat, acc0, pop0, target, guard;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_y = '0; i_cb = '0; i_cr = '0; i_last = 1'b0; i_user = 1'b0;
        repeat (3) cycle();
        check("rst_o_valid", 128'(o_valid), 128'(0));
        check("rst_o_ready", 128'(o_ready), 128'(1));
        check("rst_outputs", 128'({o_last, o_user, o_r, o_g, o_b}), 128'(0));
        i_rst = 1'b0;
        cycle();

        // Black point and first-beat latency
        i_ready = 1'b1;
        send_const(8'd16, 8'd128, 8'd128, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        lat = 1;
        while (!o_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check("latency", 128'(lat), 128'(5));
        drain(20);

        // Directed colour points, back to back
        send_const(8'd235, 8'd128, 8'd128, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
        send_const(8'd81,  8'd90,  8'd240, 1'b0, 1'b1, 8'd255, 8'd0,   8'd0);
        send_const(8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 8'd255, 8'd125, 8'd255);
        drain(30);
        check("directed_drained", 128'(q.size()), 128'(0));

        // Backpressure: only FIFO_DEPTH beats may enter
        i_ready = 1'b0;
        acc0 = acc_count; pop0 = pop_count;
        repeat (20) begin
            rand_inputs();
            i_valid = 1'b1;
            cycle();
        end
        check("bp_accepted", 128'(acc_count - acc0), 128'(8));
        check("bp_ready_low", 128'(o_ready), 128'(0));
        drain(50);
        check("bp_popped", 128'(pop_count - pop0), 128'(8));
        check("bp_drained", 128'(q.size()), 128'(0));

        // Random traffic against the reference model
        target = acc_count + 10000;
        guard = 0;
        while (acc_count < target && guard < 60000) begin
            rand_inputs();
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check("rand_accepted", 128'(acc_count), 128'(target));
        drain(100);
        check("rand_drained", 128'(q.size()), 128'(0));

        // Reset with 5 beats buffered and 3 in the datapath
        i_ready = 1'b0;
        repeat (5) begin
            rand_inputs();
            i_valid = 1'b1;
            cycle();
        end
        i_valid = 1'b0;
        repeat (6) cycle();
        check("pre_rst_valid", 128'(o_valid), 128'(1));
        repeat (3) begin
            rand_inputs();
            i_valid = 1'b1;
            cycle();
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        check("midrst_o_valid", 128'(o_valid), 128'(0));
        check("midrst_o_ready", 128'(o_ready), 128'(1));
        check("midrst_outputs", 128'({o_last, o_user, o_r, o_g, o_b}), 128'(0));
        i_ready = 1'b1;
        pop0 = pop_count;
        repeat (20) cycle();
        check("midrst_no_stale", 128'(pop_count - pop0), 128'(0));

        // Recovery after reset
        rand_inputs();
        i_valid = 1'b1;
        cycle();
        drain(20);
        check("recover_drained", 128'(q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
